wb_arbiter: RTL

Writeback arbiter and register scoreboard sitting between the execution units and the register file write port. It accepts completed results from the ALU and the load/store unit over valid/ready handshakes and arbitrates round-robin when both present a result. The winner is driven onto a registered single write port (Wen/Wnum/Wd). It also keeps a 32-bit pending-destination vector so decode can stall on operands whose producer has not yet written back.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_scoreboard.sv | 44 ++++
 rtl/wb_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its register scoreboard.
`ifndef XLEN
`define XLEN 32
`endif

package wb_pkg;

  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [`XLEN-1:0]     data;
  } wb_req_t;

  // One-hot mask for a register index; x0 never produces a bit.
  function automatic logic [NREGS-1:0] reg_mask(input logic [REG_IDX_W-1:0] idx);
    reg_mask = '0;
    if (idx != '0) reg_mask[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination vector: set on issue, cleared on register file write,
// plus the sticky protocol-error flag.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_issue_valid,
  input  logic [REG_IDX_W-1:0] i_issue_rd,
  input  logic                 i_commit,
  input  logic [REG_IDX_W-1:0] i_commit_rd,
  input  logic                 i_accept,
  input  logic [REG_IDX_W-1:0] i_accept_rd,
  output logic [NREGS-1:0]     o_busy,
  output logic                 o_err
);

  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] busy_d;
  logic             waw_err;
  logic             orphan_err;

  always_comb begin
    set_mask   = i_issue_valid ? reg_mask(i_issue_rd) : '0;
    clr_mask   = i_commit ? reg_mask(i_commit_rd) : '0;
    // Set is applied after clear so a same-edge re-issue keeps the bit.
    busy_d     = (o_busy & ~clr_mask) | set_mask;
    // A register whose write completes on this edge is free to be re-issued.
    waw_err    = |(set_mask & o_busy & ~clr_mask);
    orphan_err = i_accept && (i_accept_rd != '0) && !o_busy[i_accept_rd];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy <= '0;
      o_err  <= 1'b0;
    end else begin
      o_busy <= busy_d;
      o_err  <= o_err | waw_err | orphan_err;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter between ALU and LSU results, driving a
// registered register-file write port and the operand scoreboard.
`ifndef XLEN
`define XLEN 32
`endif

module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_issue_valid,
  input  logic [REG_IDX_W-1:0] i_issue_rd,
  output logic [NREGS-1:0]     o_busy,
  output logic                 o_err,
  input  logic                 i_alu_valid,
  input  logic [REG_IDX_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]      i_alu_data,
  output logic                 o_alu_ready,
  input  logic                 i_lsu_valid,
  input  logic [REG_IDX_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]      i_lsu_data,
  output logic                 o_lsu_ready,
  output logic                 o_Wen,
  output logic [REG_IDX_W-1:0] o_Wnum,
  output logic [XLEN-1:0]      o_Wd
);

  // Handshake: a result transfers on a rising edge with valid && ready. A source
  // holds valid/rd/data until accepted and never looks at ready to form valid;
  // ready is a combinational function of both valids and rr_q only, because the
  // write port drains every cycle and can never push back.

  wb_src_e rr_q;  // source that wins the next contended cycle
  wb_req_t alu_req;
  wb_req_t lsu_req;
  wb_req_t win_req;
  logic    contended;
  logic    grant_alu;
  logic    grant_lsu;
  logic    xfer;

  always_comb begin
    alu_req.rd   = i_alu_rd;
    alu_req.data = i_alu_data;
    lsu_req.rd   = i_lsu_rd;
    lsu_req.data = i_lsu_data;
    contended    = i_alu_valid && i_lsu_valid;
    grant_alu    = i_alu_valid && (!i_lsu_valid || rr_q == WB_SRC_ALU);
    grant_lsu    = i_lsu_valid && (!i_alu_valid || rr_q == WB_SRC_LSU);
    xfer         = grant_alu || grant_lsu;
    win_req      = grant_lsu ? lsu_req : alu_req;
  end

  assign o_alu_ready = grant_alu;
  assign o_lsu_ready = grant_lsu;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_q   <= WB_SRC_LSU;
      o_Wen  <= 1'b0;
      o_Wnum <= '0;
      o_Wd   <= '0;
    end else begin
      if (contended) rr_q <= grant_alu ? WB_SRC_LSU : WB_SRC_ALU;
      o_Wen <= xfer && (win_req.rd != '0);
      if (xfer) begin
        o_Wnum <= win_req.rd;
        o_Wd   <= win_req.data;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_commit      (o_Wen),
    .i_commit_rd   (o_Wnum),
    .i_accept      (xfer),
    .i_accept_rd   (win_req.rd),
    .o_busy        (o_busy),
    .o_err         (o_err)
  );

endmodule
